// File: rtl/ox_pkg.sv
// Shared definitions for the OX endpoint TX path.
//   ox_arb_state_t     : TX stream arbiter state encoding (IDLE, XFER, DRAIN)
//   OX_AXIS_DATA_W     : default SFP TX stream data width
//   OX_AXIS_DEST_W     : default tDest width
//   OX_MAX_FRAME_BEATS : default frame length limit in beats
//   ox_idx_w()         : index width for an n-entry vector (never below 1 bit)
package ox_pkg;

  localparam int OX_AXIS_DATA_W     = 64;
  localparam int OX_AXIS_DEST_W     = 4;
  localparam int OX_MAX_FRAME_BEATS = 190;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } ox_arb_state_t;

  function automatic int ox_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ox_rr_picker.sv
// Combinational rotating-priority encoder.
// Scans the request vector starting at the entry just after last_i
// (wrapping) and returns the first requesting index.
//   req_i     : request vector, one bit per requester
//   last_i    : index of the most recent grant
//   grant_o   : chosen index (equals last_i when nothing requests)
//   any_req_o : at least one request bit is set
module ox_rr_picker
  import ox_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = ox_idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] grant_o,
  output logic          any_req_o
);

  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    grant_o   = last_i;
    any_req_o = |req_i;
    found     = 1'b0;
    idx       = '0;
    // Offset 1 first so the previous owner has the lowest priority.
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_i) + k) % N);
      if (!found && req_i[idx]) begin
        grant_o = idx;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ox_tx_stream_arbiter.sv
// Packet-granular arbiter sharing the SFP TX AXI-Stream port between
// NUM_REQ frame sources. Frames are never interleaved; the grant is held
// from the first beat until the owner's tlast is accepted. All master-side
// outputs come straight from registers.
//
// Ports:
//   sfp_axis_tx_aclk / sfp_axis_tx_areset : clock, synchronous active-high reset
//   s_axis_*   : NUM_REQ packed slave streams (requester i at slice i)
//   m_axis_*   : single registered master stream to the MAC
//   grant_id   : index of the current or most recent owner
//   busy       : a frame is in progress (XFER or DRAIN)
//   frame_err  : one-cycle pulse when an over-length frame is cut short
//
// Build option OX_TX_ARB_CTRL_PRIO_EN: requester 0 wins every arbitration
// it takes part in; requesters 1..NUM_REQ-1 rotate among themselves with
// their own last-grant pointer. Undefined: plain round-robin over all.
module ox_tx_stream_arbiter
  import ox_pkg::*;
#(
  parameter  int NUM_REQ   = 2,
  parameter  int DATA_W    = OX_AXIS_DATA_W,
  parameter  int DEST_W    = OX_AXIS_DEST_W,
  parameter  int MAX_BEATS = OX_MAX_FRAME_BEATS,
  localparam int KEEP_W    = DATA_W / 8,
  localparam int GNT_W     = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic                      sfp_axis_tx_aclk,
  input  logic                      sfp_axis_tx_areset,
  input  logic [NUM_REQ-1:0]        s_axis_tvalid,
  output logic [NUM_REQ-1:0]        s_axis_tready,
  input  logic [NUM_REQ*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_REQ*KEEP_W-1:0] s_axis_tkeep,
  input  logic [NUM_REQ-1:0]        s_axis_tlast,
  input  logic [NUM_REQ*DEST_W-1:0] s_axis_tDest,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic [KEEP_W-1:0]         m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic [DEST_W-1:0]         m_axis_tDest,
  output logic [GNT_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      frame_err
);

  ox_arb_state_t     state_q, state_d;
  logic [GNT_W-1:0]  grant_q, grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              m_tvalid_q, m_tvalid_d;
  logic [DATA_W-1:0] m_tdata_q, m_tdata_d;
  logic [KEEP_W-1:0] m_tkeep_q, m_tkeep_d;
  logic              m_tlast_q, m_tlast_d;
  logic [DEST_W-1:0] m_tdest_q, m_tdest_d;
  logic              frame_err_q, frame_err_d;

  // Arbitration result presented to the IDLE state.
  logic [GNT_W-1:0]  arb_gnt;
  logic              arb_any;

  // ------------------------------------------------------------------
  // Arbitration
  // ------------------------------------------------------------------
`ifdef OX_TX_ARB_CTRL_PRIO_EN
  localparam int HW = ox_idx_w(NUM_REQ - 1);

  logic [HW-1:0] hi_last_q, hi_last_d;
  logic [HW-1:0] hi_gnt;
  logic          hi_any;

  // Rotation among requesters 1..NUM_REQ-1 only; requester 0 bypasses it.
  ox_rr_picker #(
    .N  (NUM_REQ - 1),
    .IW (HW)
  ) u_hi_picker (
    .req_i     (s_axis_tvalid[NUM_REQ-1:1]),
    .last_i    (hi_last_q),
    .grant_o   (hi_gnt),
    .any_req_o (hi_any)
  );

  always_comb begin
    arb_any   = |s_axis_tvalid;
    arb_gnt   = grant_q;
    hi_last_d = hi_last_q;
    if (s_axis_tvalid[0]) begin
      arb_gnt = '0;
    end else if (hi_any) begin
      arb_gnt = GNT_W'(int'(hi_gnt) + 1);
      // Only advance the upper pointer when an upper requester is granted.
      if (state_q == IDLE) begin
        hi_last_d = hi_gnt;
      end
    end
  end

  always_ff @(posedge sfp_axis_tx_aclk) begin
    if (sfp_axis_tx_areset) begin
      // Points at the last upper requester so requester 1 goes first.
      hi_last_q <= HW'(NUM_REQ - 2);
    end else begin
      hi_last_q <= hi_last_d;
    end
  end
`else
  ox_rr_picker #(
    .N  (NUM_REQ),
    .IW (GNT_W)
  ) u_picker (
    .req_i     (s_axis_tvalid),
    .last_i    (grant_q),
    .grant_o   (arb_gnt),
    .any_req_o (arb_any)
  );
`endif

  // ------------------------------------------------------------------
  // Selected requester and handshake
  // ------------------------------------------------------------------
  logic              sel_valid;
  logic              sel_last;
  logic              sel_ready;
  logic [DATA_W-1:0] sel_data;
  logic [KEEP_W-1:0] sel_keep;
  logic [DEST_W-1:0] sel_dest;
  logic              out_free;

  assign sel_valid = s_axis_tvalid[grant_q];
  assign sel_last  = s_axis_tlast[grant_q];
  assign sel_data  = s_axis_tdata[int'(grant_q)*DATA_W +: DATA_W];
  assign sel_keep  = s_axis_tkeep[int'(grant_q)*KEEP_W +: KEEP_W];
  assign sel_dest  = s_axis_tDest[int'(grant_q)*DEST_W +: DEST_W];

  // The output register can take a beat if empty or being emptied now.
  assign out_free  = !m_tvalid_q || m_axis_tready;
  // DRAIN swallows beats unconditionally; nothing reaches the output.
  assign sel_ready = ((state_q == XFER) && out_free) || (state_q == DRAIN);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign s_axis_tready[gi] = (grant_q == GNT_W'(gi)) && sel_ready;
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    m_tvalid_d  = m_tvalid_q;
    m_tdata_d   = m_tdata_q;
    m_tkeep_d   = m_tkeep_q;
    m_tlast_d   = m_tlast_q;
    m_tdest_d   = m_tdest_q;
    frame_err_d = 1'b0;

    if (m_tvalid_q && m_axis_tready) begin
      m_tvalid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d = arb_gnt;
          cnt_d   = '0;
          state_d = XFER;
        end
      end

      XFER: begin
        if (sel_valid && out_free) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = sel_data;
          m_tkeep_d  = sel_keep;
          m_tdest_d  = sel_dest;
          if (cnt_q != CNT_W'(MAX_BEATS)) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (sel_last) begin
            m_tlast_d = 1'b1;
            state_d   = IDLE;
          end else if (cnt_q == CNT_W'(MAX_BEATS - 1)) begin
            // Limit reached without tlast: close the frame ourselves and
            // throw away the rest of the source's frame.
            m_tlast_d   = 1'b1;
            frame_err_d = 1'b1;
            state_d     = DRAIN;
          end else begin
            m_tlast_d = 1'b0;
          end
        end
      end

      DRAIN: begin
        if (sel_valid && sel_last) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sfp_axis_tx_aclk) begin
    if (sfp_axis_tx_areset) begin
      state_q     <= IDLE;
      grant_q     <= GNT_W'(NUM_REQ - 1);
      cnt_q       <= '0;
      m_tvalid_q  <= 1'b0;
      m_tdata_q   <= '0;
      m_tkeep_q   <= '0;
      m_tlast_q   <= 1'b0;
      m_tdest_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tdata_q   <= m_tdata_d;
      m_tkeep_q   <= m_tkeep_d;
      m_tlast_q   <= m_tlast_d;
      m_tdest_q   <= m_tdest_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tkeep  = m_tkeep_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tDest  = m_tdest_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q != IDLE);
  assign frame_err     = frame_err_q;

endmodule
